// File: rtl/axil_pkg.sv
// Shared definitions for the AXI4-Lite RAM responder: response codes,
// FSM state encodings and address-window helpers.
// Optional build macro: AXIL_RAM_RD_PIPE_EN (adds a read output register stage).
package axil_pkg;

    localparam logic [1:0] AXIL_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXIL_RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE  = 2'd0,
        W_GOT_A = 2'd1,
        W_GOT_D = 2'd2,
        W_RESP  = 2'd3
    } w_state_t;

`ifdef AXIL_RAM_RD_PIPE_EN
    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_DATA = 2'd2
    } r_state_t;
`else
    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_DATA = 2'd1
    } r_state_t;
`endif

    // Offset from the base is taken modulo 2^32, so addresses below the
    // base wrap to large offsets and fall outside the window.
    function automatic logic addr_in_window(input logic [31:0] addr,
                                            input logic [31:0] base,
                                            input logic [31:0] win_bytes);
        return ((addr - base) < win_bytes);
    endfunction

    function automatic logic [1:0] window_resp(input logic in_win);
        return in_win ? AXIL_RESP_OKAY : AXIL_RESP_SLVERR;
    endfunction

endpackage

// File: rtl/axi_lite_if.sv
// AXI4-Lite bus bundle: 32-bit address/data, byte strobes, 2-bit responses.
interface axi_lite_if;

    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;

    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;

    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;

    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input rdata, rresp, rvalid, output rready
    );

    modport slave (
        input awaddr, awprot, awvalid, output awready,
        input wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );

endinterface

// File: rtl/sdp_ram_be.sv
// Simple dual-port word RAM: synchronous byte-enabled write port and a
// synchronous read port. A read and write to the same word in one cycle
// returns the previous contents. Contents are never reset.
module sdp_ram_be #(
    parameter int    DEPTH_WORDS = 1024,
    parameter string INIT_FILE   = "",
    parameter int    ADDR_W      = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [31:0]       wdata,
    input  logic [3:0]        wbe,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [31:0]       rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    // Byte-lane write: only lanes with their enable set are updated
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (wbe[i]) begin
                    mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    // Registered read; the old word is returned on a same-cycle write
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/axil_ram_slave.sv
// AXI4-Lite responder owning a word-organised RAM. Independent write and
// read FSMs; out-of-window accesses get SLVERR and never touch the RAM.
// Optional build macro: AXIL_RAM_RD_PIPE_EN (read latency 2 instead of 1).
module axil_ram_slave
    import axil_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
    parameter int          DEPTH_WORDS = 1024,
    parameter string       INIT_FILE   = ""
) (
    input logic        clk,
    input logic        rst,
    axi_lite_if.slave  s_if
);

    localparam int          ADDR_W    = $clog2(DEPTH_WORDS);
    localparam logic [31:0] WIN_BYTES = 32'(DEPTH_WORDS) << 2;

    function automatic logic [ADDR_W-1:0] word_index(input logic [31:0] addr);
        return ADDR_W'((addr - BASE_ADDR) >> 2);
    endfunction

    // Protection bits are accepted and ignored
    logic prot_unused_s;
    assign prot_unused_s = ^{s_if.awprot, s_if.arprot};

    // ---------------- write side ----------------
    w_state_t    w_state_r;
    logic        awready_r;
    logic        wready_r;
    logic        bvalid_r;
    logic [1:0]  bresp_r;
    logic [31:0] awaddr_r;
    logic [31:0] wdata_r;
    logic [3:0]  wstrb_r;

    logic        aw_hs_s;
    logic        w_hs_s;
    logic        wr_done_s;
    logic        wr_in_win_s;
    logic        wr_en_s;
    logic [31:0] wr_addr_s;
    logic [31:0] wr_data_s;
    logic [3:0]  wr_strb_s;

    assign aw_hs_s = s_if.awvalid & awready_r;
    assign w_hs_s  = s_if.wvalid & wready_r;

    // Combine the latched half of a split write with the live half and flag completion
    always_comb begin
        wr_addr_s = s_if.awaddr;
        wr_data_s = s_if.wdata;
        wr_strb_s = s_if.wstrb;
        wr_done_s = 1'b0;
        case (w_state_r)
            W_IDLE: begin
                wr_done_s = aw_hs_s & w_hs_s;
            end
            W_GOT_A: begin
                wr_addr_s = awaddr_r;
                wr_done_s = w_hs_s;
            end
            W_GOT_D: begin
                wr_data_s = wdata_r;
                wr_strb_s = wstrb_r;
                wr_done_s = aw_hs_s;
            end
            W_RESP: begin
                wr_done_s = 1'b0;
            end
            default: begin
                wr_done_s = 1'b0;
            end
        endcase
    end

    assign wr_in_win_s = addr_in_window(wr_addr_s, BASE_ADDR, WIN_BYTES);
    assign wr_en_s     = wr_done_s & wr_in_win_s;

    // Write FSM: capture AW/W in either order, then hold the response until bready
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state_r <= W_IDLE;
            awready_r <= 1'b1;
            wready_r  <= 1'b1;
            bvalid_r  <= 1'b0;
            bresp_r   <= AXIL_RESP_OKAY;
            awaddr_r  <= 32'h0;
            wdata_r   <= 32'h0;
            wstrb_r   <= 4'h0;
        end else if (wr_done_s) begin
            w_state_r <= W_RESP;
            awready_r <= 1'b0;
            wready_r  <= 1'b0;
            bvalid_r  <= 1'b1;
            bresp_r   <= window_resp(wr_in_win_s);
        end else begin
            case (w_state_r)
                W_IDLE: begin
                    if (aw_hs_s) begin
                        awaddr_r  <= s_if.awaddr;
                        awready_r <= 1'b0;
                        w_state_r <= W_GOT_A;
                    end else if (w_hs_s) begin
                        wdata_r   <= s_if.wdata;
                        wstrb_r   <= s_if.wstrb;
                        wready_r  <= 1'b0;
                        w_state_r <= W_GOT_D;
                    end
                end
                W_RESP: begin
                    if (s_if.bready) begin
                        bvalid_r  <= 1'b0;
                        awready_r <= 1'b1;
                        wready_r  <= 1'b1;
                        w_state_r <= W_IDLE;
                    end
                end
                W_GOT_A, W_GOT_D: begin
                    w_state_r <= w_state_r;
                end
                default: begin
                    w_state_r <= W_IDLE;
                    awready_r <= 1'b1;
                    wready_r  <= 1'b1;
                    bvalid_r  <= 1'b0;
                end
            endcase
        end
    end

    assign s_if.awready = awready_r;
    assign s_if.wready  = wready_r;
    assign s_if.bvalid  = bvalid_r;
    assign s_if.bresp   = bresp_r;

    // ---------------- read side ----------------
    r_state_t    r_state_r;
    logic        arready_r;
    logic        rvalid_r;
    logic [1:0]  rresp_r;
    logic        rd_keep_r;

    logic        ar_hs_s;
    logic        rd_in_win_s;
    logic        rd_en_s;
    logic [31:0] ram_q_s;

    assign ar_hs_s     = s_if.arvalid & arready_r;
    assign rd_in_win_s = addr_in_window(s_if.araddr, BASE_ADDR, WIN_BYTES);
    assign rd_en_s     = ar_hs_s & rd_in_win_s;

    sdp_ram_be #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .INIT_FILE   (INIT_FILE)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en_s),
        .waddr (word_index(wr_addr_s)),
        .wdata (wr_data_s),
        .wbe   (wr_strb_s),
        .re    (rd_en_s),
        .raddr (word_index(s_if.araddr)),
        .rdata (ram_q_s)
    );

`ifdef AXIL_RAM_RD_PIPE_EN
    logic [31:0] rdata_r;

    // Read FSM with an extra stage that registers the RAM output before rvalid
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_r <= R_IDLE;
            arready_r <= 1'b1;
            rvalid_r  <= 1'b0;
            rresp_r   <= AXIL_RESP_OKAY;
            rd_keep_r <= 1'b0;
            rdata_r   <= 32'h0;
        end else begin
            case (r_state_r)
                R_IDLE: begin
                    if (ar_hs_s) begin
                        arready_r <= 1'b0;
                        rresp_r   <= window_resp(rd_in_win_s);
                        rd_keep_r <= rd_in_win_s;
                        r_state_r <= R_WAIT;
                    end
                end
                R_WAIT: begin
                    rdata_r   <= rd_keep_r ? ram_q_s : 32'h0;
                    rvalid_r  <= 1'b1;
                    r_state_r <= R_DATA;
                end
                R_DATA: begin
                    if (s_if.rready) begin
                        rvalid_r  <= 1'b0;
                        arready_r <= 1'b1;
                        r_state_r <= R_IDLE;
                    end
                end
                default: begin
                    r_state_r <= R_IDLE;
                    arready_r <= 1'b1;
                    rvalid_r  <= 1'b0;
                end
            endcase
        end
    end

    assign s_if.rdata = rdata_r;
`else
    // Read FSM: the RAM read register is the data stage, so rvalid follows the handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_r <= R_IDLE;
            arready_r <= 1'b1;
            rvalid_r  <= 1'b0;
            rresp_r   <= AXIL_RESP_OKAY;
            rd_keep_r <= 1'b0;
        end else begin
            case (r_state_r)
                R_IDLE: begin
                    if (ar_hs_s) begin
                        arready_r <= 1'b0;
                        rvalid_r  <= 1'b1;
                        rresp_r   <= window_resp(rd_in_win_s);
                        rd_keep_r <= rd_in_win_s;
                        r_state_r <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (s_if.rready) begin
                        rvalid_r  <= 1'b0;
                        arready_r <= 1'b1;
                        rd_keep_r <= 1'b0;
                        r_state_r <= R_IDLE;
                    end
                end
                default: begin
                    r_state_r <= R_IDLE;
                    arready_r <= 1'b1;
                    rvalid_r  <= 1'b0;
                    rd_keep_r <= 1'b0;
                end
            endcase
        end
    end

    // RAM register is held between reads, so gating it keeps rdata stable;
    // the gate also forces zero for out-of-window reads and while idle.
    assign s_if.rdata = ram_q_s & {32{rd_keep_r}};
`endif

    assign s_if.arready = arready_r;
    assign s_if.rvalid  = rvalid_r;
    assign s_if.rresp   = rresp_r;

endmodule

// File: tb/tb_axil_ram_slave.sv
// Self-checking bench for axil_ram_slave: directed scenarios plus randomized
// traffic checked against a word-array reference model.
module tb_axil_ram_slave;

    localparam logic [31:0] BASE  = 32'h1000_0000;
    localparam int          DEPTH = 1024;
`ifdef AXIL_RAM_RD_PIPE_EN
    localparam int RD_LAT = 2;
`else
    localparam int RD_LAT = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axi_lite_if bus ();

    axil_ram_slave #(
        .BASE_ADDR   (BASE),
        .DEPTH_WORDS (DEPTH),
        .INIT_FILE   ("")
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .s_if (bus)
    );

    int vectors     = 0;
    int miscompares = 0;
    logic [31:0] model [DEPTH];

    function automatic bit in_win(input logic [31:0] a);
        longint off;
        off = longint'(a) - longint'(BASE);
        return (off >= 0) && (off < longint'(DEPTH) * 4);
    endfunction

    function automatic int word_of(input logic [31:0] a);
        return int'((longint'(a) - longint'(BASE)) / 4);
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly, input int hold, output logic [1:0] resp);
        bit aw_done = 1'b0;
        bit w_done  = 1'b0;
        bit aw_hs, w_hs;
        int cyc = 0;
        logic [1:0] want_resp;
        want_resp = in_win(addr) ? 2'b00 : 2'b10;
        @(negedge clk);
        while (!(aw_done && w_done) && cyc < 40) begin
            bus.awvalid = !aw_done && (cyc >= aw_dly);
            bus.awaddr  = addr;
            bus.awprot  = 3'd0;
            bus.wvalid  = !w_done && (cyc >= w_dly);
            bus.wdata   = data;
            bus.wstrb   = strb;
            aw_hs = bus.awvalid && bus.awready;
            w_hs  = bus.wvalid && bus.wready;
            @(negedge clk);
            cyc++;
            aw_done |= aw_hs;
            w_done  |= w_hs;
            if (aw_done != w_done) begin
                check_eq("awready_split", bus.awready, !aw_done);
                check_eq("wready_split", bus.wready, !w_done);
            end
        end
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        check_eq("aw_w_accepted", {aw_done, w_done}, 2'b11);
        check_eq("bvalid_next", bus.bvalid, 1'b1);
        check_eq("bresp", bus.bresp, want_resp);
        resp = bus.bresp;
        for (int i = 0; i < hold; i++) begin
            bus.awvalid = 1'b1;
            bus.wvalid  = 1'b1;
            bus.awaddr  = addr ^ 32'h4;
            @(negedge clk);
            check_eq("bvalid_hold", bus.bvalid, 1'b1);
            check_eq("bresp_hold", bus.bresp, want_resp);
            check_eq("aw_blocked", bus.awready, 1'b0);
            check_eq("w_blocked", bus.wready, 1'b0);
        end
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        bus.bready  = 1'b1;
        @(negedge clk);
        bus.bready = 1'b0;
        check_eq("bvalid_clear", bus.bvalid, 1'b0);
        check_eq("awready_idle", bus.awready, 1'b1);
        check_eq("wready_idle", bus.wready, 1'b1);
        if (in_win(addr)) begin
            for (int b = 0; b < 4; b++) begin
                if (strb[b]) model[word_of(addr)][8*b +: 8] = data[8*b +: 8];
            end
        end
    endtask

    task automatic do_read(input logic [31:0] addr, input int ar_dly, input int hold,
                           output logic [31:0] data);
        int cyc = 0;
        int lat;
        bit accepted;
        logic [31:0] want_d;
        logic [1:0]  want_r;
        @(negedge clk);
        repeat (ar_dly) @(negedge clk);
        bus.arvalid = 1'b1;
        bus.araddr  = addr;
        bus.arprot  = 3'd0;
        while (!bus.arready && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        accepted = bus.arready;
        want_d = in_win(addr) ? model[word_of(addr)] : 32'h0;
        want_r = in_win(addr) ? 2'b00 : 2'b10;
        @(negedge clk);
        bus.arvalid = 1'b0;
        lat = 1;
        while (!bus.rvalid && lat < 8) begin
            check_eq("ar_blocked_wait", bus.arready, 1'b0);
            @(negedge clk);
            lat++;
        end
        check_eq("ar_accepted", accepted, 1'b1);
        check_eq("rd_latency", lat, RD_LAT);
        check_eq("rdata", bus.rdata, want_d);
        check_eq("rresp", bus.rresp, want_r);
        data = bus.rdata;
        for (int i = 0; i < hold; i++) begin
            bus.arvalid = 1'b1;
            bus.araddr  = addr + 32'h4;
            @(negedge clk);
            check_eq("rvalid_hold", bus.rvalid, 1'b1);
            check_eq("rdata_hold", bus.rdata, want_d);
            check_eq("rresp_hold", bus.rresp, want_r);
            check_eq("ar_blocked", bus.arready, 1'b0);
        end
        bus.arvalid = 1'b0;
        bus.rready  = 1'b1;
        @(negedge clk);
        bus.rready = 1'b0;
        check_eq("rvalid_clear", bus.rvalid, 1'b0);
        check_eq("arready_idle", bus.arready, 1'b1);
    endtask

    function automatic logic [31:0] rand_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r <= 6) return BASE + 32'(4 * $urandom_range(0, 63)) + 32'($urandom_range(0, 3));
        else if (r == 7) return BASE + 32'(4 * (DEPTH - 1)) + 32'($urandom_range(0, 3));
        else if (r == 8) return BASE + 32'(DEPTH * 4) + 32'(4 * $urandom_range(0, 15));
        else return $urandom() & 32'h0FFF_FFFF;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  r;
        logic [31:0] d, d2;
        bus.awvalid = 1'b0; bus.awaddr = 32'h0; bus.awprot = 3'd0;
        bus.wvalid  = 1'b0; bus.wdata  = 32'h0; bus.wstrb  = 4'h0;
        bus.bready  = 1'b0;
        bus.arvalid = 1'b0; bus.araddr = 32'h0; bus.arprot = 3'd0;
        bus.rready  = 1'b0;
        for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;

        // reset values
        repeat (3) @(negedge clk);
        check_eq("rst_bvalid", bus.bvalid, 1'b0);
        check_eq("rst_rvalid", bus.rvalid, 1'b0);
        check_eq("rst_bresp", bus.bresp, 2'b00);
        check_eq("rst_rresp", bus.rresp, 2'b00);
        check_eq("rst_rdata", bus.rdata, 32'h0);
        check_eq("rst_awready", bus.awready, 1'b1);
        check_eq("rst_wready", bus.wready, 1'b1);
        check_eq("rst_arready", bus.arready, 1'b1);
        rst = 1'b0;

        // preload the words used by the random phase
        for (int i = 0; i < 64; i++) do_write(BASE + 32'(4 * i), $urandom(), 4'hF, 0, 0, 0, r);
        do_write(BASE + 32'(4 * (DEPTH - 1)), $urandom(), 4'hF, 0, 0, 0, r);

        // 1: simultaneous AW/W then readback
        do_write(32'h1000_0010, 32'hDEADBEEF, 4'hF, 0, 0, 0, r);
        check_eq("t1_bresp", r, 2'b00);
        do_read(32'h1000_0010, 0, 0, d);
        check_eq("t1_rdata", d, 32'hDEADBEEF);

        // 2: W leads AW by 3 cycles, then AW leads W
        do_write(32'h1000_0010, 32'h11223344, 4'hF, 3, 0, 0, r);
        do_read(32'h1000_0010, 0, 0, d);
        check_eq("t2_w_first", d, 32'h11223344);
        do_write(32'h1000_0010, 32'h55667788, 4'hF, 0, 3, 0, r);
        do_read(32'h1000_0010, 0, 0, d);
        check_eq("t2_aw_first", d, 32'h55667788);

        // 3: single byte strobe
        do_write(32'h1000_0010, 32'hDEADBEEF, 4'hF, 0, 0, 0, r);
        do_write(32'h1000_0010, 32'h0000_00AA, 4'b0001, 0, 0, 0, r);
        do_read(32'h1000_0010, 0, 0, d);
        check_eq("t3_strobe", d, 32'hDEADBEAA);

        // 4: out-of-window accesses
        do_write(32'h0040_0000, 32'hCAFE_F00D, 4'hF, 0, 0, 0, r);
        check_eq("t4_bresp", r, 2'b10);
        do_read(32'h1000_1000, 0, 0, d);
        check_eq("t4_rdata", d, 32'h0);
        do_read(BASE, 0, 0, d);

        // window edges
        do_write(BASE + 32'(DEPTH * 4 - 4), 32'hA5A5_5A5A, 4'hF, 1, 0, 0, r);
        do_read(BASE + 32'(DEPTH * 4 - 4), 0, 0, d);
        check_eq("edge_last", d, 32'hA5A5_5A5A);
        do_read(BASE + 32'(DEPTH * 4), 0, 0, d);
        do_read(BASE - 32'h4, 0, 0, d);

        // 5: responses held for 5 cycles on both channels
        fork
            do_write(BASE + 32'h14, 32'h0BAD_CAFE, 4'hF, 0, 0, 5, r);
            do_read(BASE + 32'h10, 0, 5, d);
        join

        // same-cycle read and write to one word returns old data
        d2 = model[4];
        fork
            do_write(BASE + 32'h10, 32'h1357_9BDF, 4'hF, 0, 0, 0, r);
            do_read(BASE + 32'h10, 0, 0, d);
        join
        check_eq("rbw_old", d, d2);
        do_read(BASE + 32'h10, 0, 0, d);

        // 6a: reset while a write address is captured
        @(negedge clk);
        bus.awvalid = 1'b1;
        bus.awaddr  = BASE + 32'h20;
        @(negedge clk);
        bus.awvalid = 1'b0;
        check_eq("t6_got_a_awready", bus.awready, 1'b0);
        check_eq("t6_got_a_wready", bus.wready, 1'b1);
        rst = 1'b1;
        #1;
        check_eq("t6_rst_bvalid", bus.bvalid, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        check_eq("t6_awready", bus.awready, 1'b1);
        check_eq("t6_wready", bus.wready, 1'b1);

        // 6b: reset while read data is pending
        bus.arvalid = 1'b1;
        bus.araddr  = BASE;
        @(negedge clk);
        bus.arvalid = 1'b0;
        repeat (RD_LAT - 1) @(negedge clk);
        check_eq("t6_rvalid_pre", bus.rvalid, 1'b1);
        rst = 1'b1;
        #1;
        check_eq("t6_rst_rvalid", bus.rvalid, 1'b0);
        check_eq("t6_rst_bvalid2", bus.bvalid, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        check_eq("t6_arready", bus.arready, 1'b1);
        check_eq("t6_awready2", bus.awready, 1'b1);
        check_eq("t6_wready2", bus.wready, 1'b1);
        do_read(BASE + 32'h20, 0, 0, d);
        do_read(BASE, 0, 0, d);

        // randomized traffic
        for (int n = 0; n < 200; n++) begin
            logic [31:0] a;
            int op;
            a  = rand_addr();
            op = $urandom_range(0, 4);
            if (op <= 1) begin
                do_write(a, $urandom(), 4'($urandom_range(0, 15)),
                         $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), r);
            end else if (op <= 3) begin
                do_read(a, $urandom_range(0, 2), $urandom_range(0, 3), d);
            end else begin
                fork
                    do_write(a, $urandom(), 4'hF, 0, 0, $urandom_range(0, 2), r);
                    do_read(a, 0, $urandom_range(0, 2), d);
                join
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
